// File: rtl/voice_phase_sequencer.sv
// Per-tick voice sweep for the wavetable oscillator: reads each voice's phase
// accumulator, presents the 10-bit phase downstream, and writes back acc + delta.
module voice_phase_sequencer #(
  parameter int NUM_VOICES = 128,
  parameter int ACC_W      = 24
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_sample_tick,
  input  logic             i_upd_valid,
  output logic             o_upd_ready,
  input  logic [7:0]       i_upd_voice,
  input  logic [ACC_W-1:0] i_upd_delta,
  input  logic [3:0]       i_upd_wave,
  input  logic             i_upd_gate,
  output logic [9:0]       o_phase,
  output logic [3:0]       o_wave_select,
  output logic             o_voice_active,
  output logic [7:0]       o_voice_index,
  output logic [1:0]       o_pipeline_state,
  output logic             o_busy,
  output logic             o_frame_done,
  output logic             o_overrun
);

  localparam int         IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [7:0] LAST  = 8'(NUM_VOICES - 1);

  typedef enum logic [2:0] {ST_INIT, ST_IDLE, ST_S0, ST_S1, ST_S2} state_t;
  state_t state, state_n;

  logic [ACC_W-1:0] acc_mem   [NUM_VOICES];
  logic [ACC_W-1:0] delta_mem [NUM_VOICES];
  logic [3:0]       wave_mem  [NUM_VOICES];
  logic             act_mem   [NUM_VOICES];

  logic [7:0]       idx, idx_n, init_cnt;
  logic [ACC_W-1:0] rd_acc, rd_delta;
  logic [3:0]       rd_wave;
  logic             rd_act;

  logic             upd_pend, upd_gate, upd_apply;
  logic [7:0]       upd_voice;
  logic [ACC_W-1:0] upd_delta;
  logic [3:0]       upd_wave;
  logic             upd_in_range, upd_accept;
  logic [IDX_W-1:0] uidx;

  logic             we, wact;
  logic [IDX_W-1:0] waddr;
  logic [ACC_W-1:0] wacc, wdelta;
  logic [3:0]       wwave;

  assign uidx         = upd_voice[IDX_W-1:0];
  assign upd_in_range = ({1'b0, upd_voice} < 9'(NUM_VOICES));
  assign upd_accept   = i_upd_valid && o_upd_ready;

  always_ff @(posedge i_clk) begin
    if (i_reset) state <= ST_INIT;
    else         state <= state_n;
  end

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    upd_apply = 1'b0;
    we        = 1'b0;
    waddr     = '0;
    wacc      = '0;
    wdelta    = '0;
    wwave     = '0;
    wact      = 1'b0;
    case (state)
      ST_INIT: begin
        we    = 1'b1;
        waddr = init_cnt[IDX_W-1:0];
        if (init_cnt == LAST) state_n = ST_IDLE;
      end
      ST_IDLE: begin
        if (i_sample_tick) begin
          state_n = ST_S0;
          idx_n   = '0;
        end else if (upd_pend) begin
          // Out-of-range voices are dropped so the buffer cannot wedge.
          upd_apply = 1'b1;
          we        = upd_in_range;
          waddr     = uidx;
          wdelta    = upd_delta;
          wwave     = upd_wave;
          wact      = upd_gate;
          wacc      = (upd_gate && act_mem[uidx]) ? acc_mem[uidx] : '0;
        end
      end
      ST_S0: state_n = ST_S1;
      ST_S1: state_n = ST_S2;
      ST_S2: begin
        we     = 1'b1;
        waddr  = idx[IDX_W-1:0];
        wdelta = rd_delta;
        wwave  = rd_wave;
        wact   = rd_act;
        wacc   = rd_act ? rd_acc + rd_delta : rd_acc;
        if (upd_pend && upd_voice == idx) begin
          upd_apply = 1'b1;
          wdelta    = upd_delta;
          wwave     = upd_wave;
          wact      = upd_gate;
          wacc      = (upd_gate && rd_act) ? rd_acc + rd_delta : '0;
        end
        if (idx == LAST) begin
          state_n = ST_IDLE;
        end else begin
          idx_n   = idx + 8'd1;
          state_n = ST_S0;
        end
      end
      default: state_n = ST_INIT;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (we && !i_reset) begin
      acc_mem[waddr]   <= wacc;
      delta_mem[waddr] <= wdelta;
      wave_mem[waddr]  <= wwave;
      act_mem[waddr]   <= wact;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      idx            <= '0;
      init_cnt       <= '0;
      rd_acc         <= '0;
      rd_delta       <= '0;
      rd_wave        <= '0;
      rd_act         <= 1'b0;
      upd_pend       <= 1'b0;
      upd_voice      <= '0;
      upd_delta      <= '0;
      upd_wave       <= '0;
      upd_gate       <= 1'b0;
      o_upd_ready    <= 1'b0;
      o_phase        <= '0;
      o_wave_select  <= '0;
      o_voice_active <= 1'b0;
      o_frame_done   <= 1'b0;
      o_overrun      <= 1'b0;
    end else begin
      idx <= idx_n;
      if (state == ST_INIT) init_cnt <= init_cnt + 8'd1;
      // Read data is captured in S0 and held for the S1 display and S2 writeback.
      o_phase        <= '0;
      o_wave_select  <= '0;
      o_voice_active <= 1'b0;
      if (state == ST_S0) begin
        rd_acc         <= acc_mem[idx[IDX_W-1:0]];
        rd_delta       <= delta_mem[idx[IDX_W-1:0]];
        rd_wave        <= wave_mem[idx[IDX_W-1:0]];
        rd_act         <= act_mem[idx[IDX_W-1:0]];
        o_phase        <= act_mem[idx[IDX_W-1:0]] ? acc_mem[idx[IDX_W-1:0]][ACC_W-1 -: 10] : 10'd0;
        o_wave_select  <= wave_mem[idx[IDX_W-1:0]];
        o_voice_active <= act_mem[idx[IDX_W-1:0]];
      end
      o_frame_done <= (state == ST_S2) && (idx == LAST);
      if (i_sample_tick && (state == ST_S0 || state == ST_S1 || state == ST_S2))
        o_overrun <= 1'b1;
      if (upd_apply) begin
        upd_pend <= 1'b0;
      end else if (upd_accept) begin
        upd_pend  <= 1'b1;
        upd_voice <= i_upd_voice;
        upd_delta <= i_upd_delta;
        upd_wave  <= i_upd_wave;
        upd_gate  <= i_upd_gate;
      end
      o_upd_ready <= (state_n != ST_INIT) && !((upd_pend && !upd_apply) || upd_accept);
    end
  end

  assign o_voice_index = idx;
  assign o_busy        = (state != ST_IDLE);

  always_comb begin
    case (state)
      ST_S0:   o_pipeline_state = 2'd0;
      ST_S1:   o_pipeline_state = 2'd1;
      ST_S2:   o_pipeline_state = 2'd2;
      default: o_pipeline_state = 2'd3;
    endcase
  end

endmodule

// File: tb/tb_voice_phase_sequencer.sv
// Scoreboard bench for voice_phase_sequencer with 4 voices: a behavioural voice
// model predicts each S1 observation, which is compared as the DUT produces it.
module tb_voice_phase_sequencer;
  localparam int NV = 4;
  localparam int AW = 24;

  logic          clk = 1'b0;
  logic          i_reset = 1'b1, i_sample_tick = 1'b0, i_upd_valid = 1'b0, i_upd_gate = 1'b0;
  logic [7:0]    i_upd_voice = '0;
  logic [AW-1:0] i_upd_delta = '0;
  logic [3:0]    i_upd_wave = '0;
  logic          o_upd_ready, o_voice_active, o_busy, o_frame_done, o_overrun;
  logic [9:0]    o_phase;
  logic [3:0]    o_wave_select;
  logic [7:0]    o_voice_index;
  logic [1:0]    o_pipeline_state;

  always #5 clk = ~clk;

  voice_phase_sequencer #(.NUM_VOICES(NV), .ACC_W(AW)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_sample_tick(i_sample_tick),
    .i_upd_valid(i_upd_valid), .o_upd_ready(o_upd_ready), .i_upd_voice(i_upd_voice),
    .i_upd_delta(i_upd_delta), .i_upd_wave(i_upd_wave), .i_upd_gate(i_upd_gate),
    .o_phase(o_phase), .o_wave_select(o_wave_select), .o_voice_active(o_voice_active),
    .o_voice_index(o_voice_index), .o_pipeline_state(o_pipeline_state), .o_busy(o_busy),
    .o_frame_done(o_frame_done), .o_overrun(o_overrun)
  );

  typedef struct {
    int         cyc;
    logic [7:0] voice;
    logic [9:0] phase;
    logic       act;
    logic [3:0] wave;
  } ent_t;

  ent_t exp_q[$];
  ent_t obs_q[$];
  int   rd_ptr = 0;
  int   cyc = 0;
  int   ready_rise = -1;
  logic prev_ready = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (o_pipeline_state == 2'd1)
      obs_q.push_back('{cyc, o_voice_index, o_phase, o_voice_active, o_wave_select});
    if (o_upd_ready === 1'b1 && !prev_ready) ready_rise = cyc;
    prev_ready = (o_upd_ready === 1'b1);
  end

  logic [AW-1:0] m_acc[NV], m_delta[NV];
  logic [3:0]    m_wave[NV];
  logic          m_act[NV];
  logic [9:0]    last_phase[NV];
  logic          last_act[NV];

  int n_checks = 0, n_fails = 0;
  int tick_cyc = 0;
  logic [7:0]    u_voice = '0;
  logic [AW-1:0] u_delta = '0;
  logic [3:0]    u_wave = '0;
  logic          u_gate = 1'b0;

  task automatic model_reset();
    for (int v = 0; v < NV; v++) begin
      m_acc[v] = '0; m_delta[v] = '0; m_wave[v] = '0; m_act[v] = 1'b0;
    end
  endtask

  task automatic model_apply(input int v, input logic [AW-1:0] d, input logic [3:0] w, input logic g);
    m_delta[v] = d;
    m_wave[v]  = w;
    if (!g) begin
      m_act[v] = 1'b0; m_acc[v] = '0;
    end else if (!m_act[v]) begin
      m_act[v] = 1'b1; m_acc[v] = '0;
    end
  endtask

  task automatic model_advance();
    for (int v = 0; v < NV; v++)
      if (m_act[v]) m_acc[v] = m_acc[v] + m_delta[v];
  endtask

  task automatic start_sweep();
    @(posedge clk); #1;
    tick_cyc = cyc;
    for (int v = 0; v < NV; v++)
      exp_q.push_back('{tick_cyc + 2 + 3*v, 8'(v), m_act[v] ? m_acc[v][AW-1 -: 10] : 10'd0,
                        m_act[v], m_wave[v]});
    i_sample_tick = 1'b1;
    @(posedge clk); #1;
    i_sample_tick = 1'b0;
  endtask

  task automatic sb_drain();
    ent_t o, e;
    while (rd_ptr < obs_q.size()) begin
      o = obs_q[rd_ptr];
      rd_ptr++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fails++;
        $display("FAIL sb_extra: got voice %0d phase %h at cycle %0d, required no output", o.voice, o.phase, o.cyc);
      end else begin
        e = exp_q.pop_front();
        if (o.cyc !== e.cyc || o.voice !== e.voice || o.phase !== e.phase ||
            o.act !== e.act || o.wave !== e.wave) begin
          n_fails++;
          $display("FAIL sb_voice: got cyc %0d v %0d ph %h act %b wave %h, required cyc %0d v %0d ph %h act %b wave %h",
                   o.cyc, o.voice, o.phase, o.act, o.wave, e.cyc, e.voice, e.phase, e.act, e.wave);
        end
      end
      if (o.voice < NV) begin
        last_phase[o.voice] = o.phase;
        last_act[o.voice]   = o.act;
      end
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fails++;
      $display("FAIL sb_missing: %0d outputs outstanding, required 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  // Follows one sweep; optionally injects a tick or an update at a cycle offset.
  task automatic wait_frame(input int tick_at, input int upd_at);
    int pulses = 0;
    for (int i = 1; i <= 3*NV + 6; i++) begin
      @(negedge clk);
      i_sample_tick = 1'b0;
      i_upd_valid   = 1'b0;
      if (o_frame_done) begin
        pulses++;
        n_checks++;
        if (cyc !== tick_cyc + 3*NV + 1 || o_pipeline_state !== 2'd3) begin
          n_fails++;
          $display("FAIL frame_timing: done at +%0d state %0d, required +%0d state 3",
                   cyc - tick_cyc, o_pipeline_state, 3*NV + 1);
        end
      end
      if (i == tick_at) i_sample_tick = 1'b1;
      if (i == upd_at) begin
        i_upd_valid = 1'b1; i_upd_voice = u_voice; i_upd_delta = u_delta;
        i_upd_wave = u_wave; i_upd_gate = u_gate;
      end
    end
    n_checks++;
    if (pulses != 1) begin
      n_fails++;
      $display("FAIL frame_count: %0d pulses, required 1", pulses);
    end
    sb_drain();
    model_advance();
  endtask

  task automatic send_update(input int v, input logic [AW-1:0] d, input logic [3:0] w, input logic g);
    int k = 0;
    @(negedge clk);
    while (o_upd_ready !== 1'b1 && k < 40) begin
      @(negedge clk); k++;
    end
    n_checks++;
    if (o_upd_ready !== 1'b1) begin
      n_fails++;
      $display("FAIL upd_ready_wait: got %b, required 1", o_upd_ready);
      return;
    end
    i_upd_valid = 1'b1; i_upd_voice = 8'(v); i_upd_delta = d; i_upd_wave = w; i_upd_gate = g;
    @(negedge clk);
    i_upd_valid = 1'b0;
    n_checks++;
    if (o_upd_ready !== 1'b0) begin
      n_fails++;
      $display("FAIL upd_ready_drop: got %b, required 0", o_upd_ready);
    end
    @(negedge clk);
    n_checks++;
    if (o_upd_ready !== 1'b1) begin
      n_fails++;
      $display("FAIL upd_ready_back: got %b, required 1", o_upd_ready);
    end
    model_apply(v, d, w, g);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({o_pipeline_state, o_busy, o_upd_ready, o_frame_done, o_overrun, o_phase, o_wave_select,
         o_voice_active, o_voice_index} !== {2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 4'd0, 1'b0, 8'd0}) begin
      n_fails++;
      $display("FAIL reset_outputs: state %0d busy %b rdy %b done %b ovr %b ph %h idx %0d, required 3 1 0 0 0 000 0",
               o_pipeline_state, o_busy, o_upd_ready, o_frame_done, o_overrun, o_phase, o_voice_index);
    end
    @(posedge clk); #1;
    i_reset = 1'b0;
    i_sample_tick = 1'b1;  // ticks during INIT must be ignored
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      n_checks++;
      if (o_busy !== 1'b1 || o_upd_ready !== 1'b0 || o_pipeline_state !== 2'd3) begin
        n_fails++;
        $display("FAIL init_busy[%0d]: busy %b rdy %b state %0d, required 1 0 3", i, o_busy, o_upd_ready, o_pipeline_state);
      end
      if (i == NV - 1) i_sample_tick = 1'b0;
    end
    @(negedge clk);
    n_checks++;
    if (o_busy !== 1'b0 || o_upd_ready !== 1'b1 || o_pipeline_state !== 2'd3 || o_overrun !== 1'b0) begin
      n_fails++;
      $display("FAIL init_done: busy %b rdy %b state %0d ovr %b, required 0 1 3 0", o_busy, o_upd_ready, o_pipeline_state, o_overrun);
    end
    model_reset();
    start_sweep();
    wait_frame(0, 0);
  endtask

  task automatic test_accumulation();
    logic [9:0] ph[3] = '{10'h000, 10'h010, 10'h020};
    send_update(1, 24'h040000, 4'd7, 1'b1);
    for (int s = 0; s < 3; s++) begin
      start_sweep();
      wait_frame(0, 0);
      n_checks++;
      if (last_phase[1] !== ph[s] || last_act[1] !== 1'b1) begin
        n_fails++;
        $display("FAIL accum[%0d]: phase %h act %b, required %h 1", s, last_phase[1], last_act[1], ph[s]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [9:0] ph[3] = '{10'h000, 10'h200, 10'h000};
    send_update(0, 24'h800000, 4'd2, 1'b1);
    for (int s = 0; s < 3; s++) begin
      start_sweep();
      wait_frame(0, 0);
      n_checks++;
      if (last_phase[0] !== ph[s]) begin
        n_fails++;
        $display("FAIL wrap[%0d]: phase %h, required %h", s, last_phase[0], ph[s]);
      end
    end
  endtask

  task automatic test_merge();
    send_update(2, 24'h100000, 4'd5, 1'b1);
    start_sweep();
    wait_frame(0, 0);
    u_voice = 8'd2; u_delta = 24'h000123; u_wave = 4'd3; u_gate = 1'b0;
    start_sweep();
    wait_frame(0, 1);  // accepted in voice 0's S0, before voice 2's S2
    n_checks++;
    if (ready_rise !== tick_cyc + 10) begin
      n_fails++;
      $display("FAIL merge_ready: rose at +%0d, required +10", ready_rise - tick_cyc);
    end
    n_checks++;
    if (last_phase[2] !== 10'h040 || last_act[2] !== 1'b1) begin
      n_fails++;
      $display("FAIL merge_pre: phase %h act %b, required 040 1", last_phase[2], last_act[2]);
    end
    model_apply(2, 24'h000123, 4'd3, 1'b0);
    start_sweep();
    wait_frame(0, 0);
    n_checks++;
    if (last_phase[2] !== 10'h000 || last_act[2] !== 1'b0) begin
      n_fails++;
      $display("FAIL merge_post: phase %h act %b, required 000 0", last_phase[2], last_act[2]);
    end
  endtask

  task automatic test_overrun();
    n_checks++;
    if (o_overrun !== 1'b0) begin
      n_fails++;
      $display("FAIL overrun_pre: got %b, required 0", o_overrun);
    end
    start_sweep();
    wait_frame(5, 0);
    n_checks++;
    if (o_overrun !== 1'b1) begin
      n_fails++;
      $display("FAIL overrun_set: got %b, required 1", o_overrun);
    end
    start_sweep();
    wait_frame(0, 0);
    n_checks++;
    if (o_overrun !== 1'b1) begin
      n_fails++;
      $display("FAIL overrun_sticky: got %b, required 1", o_overrun);
    end
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    start_sweep();
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (o_frame_done) pulses++;
    end
    i_reset = 1'b1;  // during voice 2's S1
    @(negedge clk);
    n_checks++;
    if (o_pipeline_state !== 2'd3 || o_busy !== 1'b1 || o_frame_done !== 1'b0) begin
      n_fails++;
      $display("FAIL reset_mid: state %0d busy %b done %b, required 3 1 0", o_pipeline_state, o_busy, o_frame_done);
    end
    i_reset = 1'b0;
    for (int i = 0; i < 3*NV + 4; i++) begin
      @(negedge clk);
      if (o_frame_done) pulses++;
    end
    n_checks++;
    if (pulses != 0 || o_busy !== 1'b0 || o_overrun !== 1'b0) begin
      n_fails++;
      $display("FAIL reset_mid_after: pulses %0d busy %b ovr %b, required 0 0 0", pulses, o_busy, o_overrun);
    end
    void'(exp_q.pop_back());  // voice 3 never reached S1
    sb_drain();
    model_reset();
    start_sweep();
    wait_frame(0, 0);
    for (int v = 0; v < NV; v++) begin
      n_checks++;
      if (last_phase[v] !== 10'h000 || last_act[v] !== 1'b0) begin
        n_fails++;
        $display("FAIL reset_clear[%0d]: phase %h act %b, required 000 0", v, last_phase[v], last_act[v]);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_accumulation();
    test_wrap();
    test_merge();
    test_overrun();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
